// File: rtl/bin_manager_pkg.sv
// Shared types and helpers for the bin load/update responder: FSM states,
// variable-state word field offsets and the global RAM address computation.
package bin_manager_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD_CLAUSE,
    LD_VAR,
    LD_DRAIN,
    UPD_VAR,
    UPD_DRAIN
  } bm_state_t;

  // Variable-state word layout: 2-bit assigned value over a 16-bit decision level.
  localparam int VAR_VALUE_MSB = 17;
  localparam int VAR_VALUE_LSB = 16;
  localparam int VAR_LEVEL_MSB = 15;
  localparam int VAR_LEVEL_LSB = 0;

  // (bin-1)*per_bin + idx, unsigned and wrapping; callers truncate to the RAM
  // address width, so the 32-bit wrap is identical modulo any narrower width.
  function automatic logic [31:0] bin_addr(input logic [31:0] bin,
                                           input logic [31:0] per_bin,
                                           input logic [31:0] idx);
    return (bin - 32'd1) * per_bin + idx;
  endfunction

endpackage

// File: rtl/bin_manager_copy_pipe.sv
// bin_copy_pipe: issues one read per enabled cycle (index 0..last_idx, then wraps)
// and echoes each read as a write one cycle later. No backpressure; en is the issue strobe.
module bin_copy_pipe #(
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tag,
  input  logic [IDX_W-1:0] last_idx,
  output logic             last,
  output logic             rd_vld,
  output logic             rd_tag,
  output logic [IDX_W-1:0] rd_idx,
  output logic             wr_vld,
  output logic             wr_tag,
  output logic [IDX_W-1:0] wr_idx
);

  logic [IDX_W-1:0] cnt;

  assign last = en && (cnt == last_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      rd_vld <= 1'b0;
      rd_tag <= 1'b0;
      rd_idx <= '0;
      wr_vld <= 1'b0;
      wr_tag <= 1'b0;
      wr_idx <= '0;
    end else begin
      rd_vld <= en;
      rd_tag <= en && tag;
      rd_idx <= en ? cnt : '0;
      if (en) begin
        cnt <= last ? '0 : cnt + IDX_W'(1);
      end
      // Read data returns one cycle after the strobe, so the write trails by one.
      wr_vld <= rd_vld;
      wr_tag <= rd_tag;
      wr_idx <= rd_idx;
    end
  end

endmodule

// File: rtl/bin_manager.sv
// Bin load/update responder: load copies a bin's clauses+vars global->local (done at T0+NC+NV+2),
// update copies vars local->global (done at T0+NV+2); starts while busy are dropped. BIN_MANAGER_BOUNDS_CHECK_EN adds bin range rejection.
module bin_manager
  import bin_manager_pkg::*;
#(
  parameter int NUM_CLAUSES_A_BIN = 8,
  parameter int NUM_VARS_A_BIN    = 18,
  parameter int WIDTH_BIN         = 16,
  parameter int WIDTH_VAR_STATE   = 18,
  parameter int ADDR_WIDTH        = 31
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start_load_i,
  input  logic                                  start_update_i,
  input  logic [WIDTH_BIN-1:0]                  request_bin_num_i,
  input  logic [WIDTH_BIN-1:0]                  total_bin_num_i,
  output logic                                  done_load_o,
  output logic                                  done_update_o,
  output logic                                  busy_o,
  output logic                                  error_o,
  output logic                                  gm_clause_re_o,
  output logic [ADDR_WIDTH-1:0]                 gm_clause_addr_o,
  input  logic [2*NUM_VARS_A_BIN-1:0]           gm_clause_i,
  output logic                                  gm_var_re_o,
  output logic                                  gm_var_we_o,
  output logic [ADDR_WIDTH-1:0]                 gm_var_addr_o,
  output logic [WIDTH_VAR_STATE-1:0]            gm_var_o,
  input  logic [WIDTH_VAR_STATE-1:0]            gm_var_i,
  output logic                                  lb_clause_we_o,
  output logic [$clog2(NUM_CLAUSES_A_BIN)-1:0]  lb_clause_idx_o,
  output logic [2*NUM_VARS_A_BIN-1:0]           lb_clause_o,
  output logic                                  lb_var_we_o,
  output logic                                  lb_var_re_o,
  output logic [$clog2(NUM_VARS_A_BIN)-1:0]     lb_var_idx_o,
  output logic [WIDTH_VAR_STATE-1:0]            lb_var_o,
  input  logic [WIDTH_VAR_STATE-1:0]            lb_var_i
);

  localparam int CLW = $clog2(NUM_CLAUSES_A_BIN);
  localparam int VW  = $clog2(NUM_VARS_A_BIN);
  localparam int LW  = (VW > CLW) ? VW : CLW;

  bm_state_t            state;
  logic [WIDTH_BIN-1:0] bin_q;
  logic                 done_load_q;
  logic                 done_update_q;
  logic                 busy_q;

  logic          accept_load;
  logic          accept_update;
  logic          bin_bad;
  logic          drain_fire;

  logic          ld_en;
  logic [LW-1:0] ld_last_idx;
  logic          ld_last;
  logic          ld_rd_vld, ld_rd_tag, ld_wr_vld, ld_wr_tag;
  logic [LW-1:0] ld_rd_idx, ld_wr_idx;

  logic          upd_en;
  logic          upd_last;
  logic          upd_rd_vld, upd_wr_vld;
  logic          upd_rd_tag, upd_wr_tag;
  logic [VW-1:0] upd_rd_idx, upd_wr_idx;

  assign accept_load   = (state == IDLE) && start_load_i;
  assign accept_update = (state == IDLE) && start_update_i && !start_load_i;

  assign drain_fire = ((state == LD_DRAIN) && !ld_rd_vld) ||
                      ((state == UPD_DRAIN) && !upd_rd_vld);

`ifdef BIN_MANAGER_BOUNDS_CHECK_EN
  logic bin_bad_q;
  logic error_q;

  assign bin_bad = (request_bin_num_i == '0) || (request_bin_num_i > total_bin_num_i);
  assign error_o = error_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_bad_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      error_q <= drain_fire && bin_bad_q;
      if (accept_load || accept_update) begin
        bin_bad_q <= bin_bad;
      end
    end
  end
`else
  logic unused_total;

  assign bin_bad      = 1'b0;
  assign error_o      = 1'b0;
  assign unused_total = ^total_bin_num_i;
`endif

  // A rejected bin skips straight to drain, which with an idle pipe fires
  // done (and error) exactly one cycle after the start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bin_q         <= '0;
      done_load_q   <= 1'b0;
      done_update_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      done_load_q   <= 1'b0;
      done_update_q <= 1'b0;
      busy_q        <= (state != IDLE) || accept_load || accept_update;
      case (state)
        IDLE: begin
          if (accept_load) begin
            bin_q <= request_bin_num_i;
            state <= bin_bad ? LD_DRAIN : LD_CLAUSE;
          end else if (accept_update) begin
            bin_q <= request_bin_num_i;
            state <= bin_bad ? UPD_DRAIN : UPD_VAR;
          end
        end
        LD_CLAUSE: if (ld_last) state <= LD_VAR;
        LD_VAR:    if (ld_last) state <= LD_DRAIN;
        LD_DRAIN: begin
          if (!ld_rd_vld) begin
            done_load_q <= 1'b1;
            state       <= IDLE;
          end
        end
        UPD_VAR:   if (upd_last) state <= UPD_DRAIN;
        UPD_DRAIN: begin
          if (!upd_rd_vld) begin
            done_update_q <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign done_load_o   = done_load_q;
  assign done_update_o = done_update_q;
  assign busy_o        = busy_q;

  // Load direction: one pipe serves both phases; tag=1 marks the variable phase.
  assign ld_en       = (state == LD_CLAUSE) || (state == LD_VAR);
  assign ld_last_idx = (state == LD_VAR) ? LW'(NUM_VARS_A_BIN - 1) : LW'(NUM_CLAUSES_A_BIN - 1);

  bin_copy_pipe #(.IDX_W(LW)) u_ld_pipe (
    .clk      (clk),
    .rst      (rst),
    .en       (ld_en),
    .tag      (state == LD_VAR),
    .last_idx (ld_last_idx),
    .last     (ld_last),
    .rd_vld   (ld_rd_vld),
    .rd_tag   (ld_rd_tag),
    .rd_idx   (ld_rd_idx),
    .wr_vld   (ld_wr_vld),
    .wr_tag   (ld_wr_tag),
    .wr_idx   (ld_wr_idx)
  );

  assign upd_en = (state == UPD_VAR);

  bin_copy_pipe #(.IDX_W(VW)) u_upd_pipe (
    .clk      (clk),
    .rst      (rst),
    .en       (upd_en),
    .tag      (1'b0),
    .last_idx (VW'(NUM_VARS_A_BIN - 1)),
    .last     (upd_last),
    .rd_vld   (upd_rd_vld),
    .rd_tag   (upd_rd_tag),
    .rd_idx   (upd_rd_idx),
    .wr_vld   (upd_wr_vld),
    .wr_tag   (upd_wr_tag),
    .wr_idx   (upd_wr_idx)
  );

  logic unused_upd_tags;
  assign unused_upd_tags = upd_rd_tag ^ upd_wr_tag;

  logic ld_rd_clause, ld_rd_var, ld_wr_clause, ld_wr_var;
  assign ld_rd_clause = ld_rd_vld && !ld_rd_tag;
  assign ld_rd_var    = ld_rd_vld && ld_rd_tag;
  assign ld_wr_clause = ld_wr_vld && !ld_wr_tag;
  assign ld_wr_var    = ld_wr_vld && ld_wr_tag;

  // Global side: clause reads, variable reads (load) or writes (update).
  assign gm_clause_re_o   = ld_rd_clause;
  assign gm_clause_addr_o = ld_rd_clause ?
      ADDR_WIDTH'(bin_addr(32'(bin_q), 32'(NUM_CLAUSES_A_BIN), 32'(ld_rd_idx))) : '0;

  assign gm_var_re_o   = ld_rd_var;
  assign gm_var_we_o   = upd_wr_vld;
  assign gm_var_addr_o = ld_rd_var  ? ADDR_WIDTH'(bin_addr(32'(bin_q), 32'(NUM_VARS_A_BIN), 32'(ld_rd_idx))) :
                         upd_wr_vld ? ADDR_WIDTH'(bin_addr(32'(bin_q), 32'(NUM_VARS_A_BIN), 32'(upd_wr_idx))) :
                         '0;
  assign gm_var_o      = upd_wr_vld ? lb_var_i : '0;

  // Local side: write data is the RAM read data returning this cycle.
  assign lb_clause_we_o  = ld_wr_clause;
  assign lb_clause_idx_o = ld_wr_clause ? ld_wr_idx[CLW-1:0] : '0;
  assign lb_clause_o     = ld_wr_clause ? gm_clause_i : '0;

  assign lb_var_we_o  = ld_wr_var;
  assign lb_var_re_o  = upd_rd_vld;
  assign lb_var_idx_o = ld_wr_var  ? VW'(ld_wr_idx) :
                        upd_rd_vld ? upd_rd_idx :
                        '0;
  assign lb_var_o     = ld_wr_var ? gm_var_i : '0;

endmodule
